// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches words from instruction memory over a
// req/ready handshake, and presents instr/opcode with valid/ack. Option: FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] retired_r;
    logic        req_r;
    logic        valid_r;
    logic        fault_r;
    logic [31:0] target_s;
    logic        timeout_s;

    function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic take,
                                            input logic [31:0] offset);
        next_pc = take ? (cur + offset) : (cur + 32'd4);
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        is_misaligned = (addr[1:0] != 2'b00);
    endfunction

    assign target_s = next_pc(pc_r, branch & zero, imm_ext);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt_r;

    // Wait counter: zero whenever outside FETCH, counts FETCH cycles without ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (state_r != FETCH) begin
            wait_cnt_r <= '0;
        end else if (!imem_ready) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The TIMEOUT_CYCLES-th waiting cycle is the last one; ready still wins on it.
    assign timeout_s = (state_r == FETCH) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled; parameter stays referenced so both builds share one interface.
    assign timeout_s = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

    // Fetch sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            instr_r   <= 32'h0000_0000;
            retired_r <= 32'h0000_0000;
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                    req_r   <= 1'b1;
                    valid_r <= 1'b0;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_r <= imem_rdata;
                        req_r   <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= HOLD;
                    end else if (timeout_s) begin
                        req_r   <= 1'b0;
                        fault_r <= 1'b1;
                        state_r <= FAULT;
                    end else begin
                        req_r   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
                        retired_r <= retired_r + 32'd1;
                        valid_r   <= 1'b0;
                        if (is_misaligned(target_s)) begin
                            fault_r <= 1'b1;
                            req_r   <= 1'b0;
                            state_r <= FAULT;
                        end else begin
                            pc_r    <= target_s;
                            req_r   <= 1'b1;
                            state_r <= FETCH;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                FAULT: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    fault_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[6:0];
    assign instr_valid = valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_r + 32'd4;
    assign retired     = retired_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized fetch
// traffic compared against a PC/retire/fault reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] imm_ext = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_fault;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .instr_ack(instr_ack), .branch(branch), .zero(zero),
        .imm_ext(imm_ext), .pc(pc), .pc_plus4(pc_plus4), .retired(retired), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_target(input logic [31:0] p, input logic br,
                                                 input logic z, input logic [31:0] imm);
        return (br && z) ? p + imm : p + 32'd4;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        imem_ready = 1'b0;
        instr_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        m_pc = 32'h0; m_ret = 32'h0; m_fault = 1'b0;
    endtask

    // Serve one fetch with 'w' wait cycles, then acknowledge with the given branch inputs.
    task automatic fetch_ack(input int w, input logic [31:0] data, input logic br,
                             input logic z, input logic [31:0] imm);
        logic [31:0] t;
        repeat (w) tick();
        imem_ready = 1'b1; imem_rdata = data;
        tick();
        imem_ready = 1'b0; imem_rdata = $urandom;
        branch = br; zero = z; imm_ext = imm; instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0; branch = 1'($urandom); zero = 1'($urandom); imm_ext = $urandom;
        t = model_target(m_pc, br, z, imm);
        m_ret = m_ret + 32'd1;
        if (t[1:0] != 2'b00) m_fault = 1'b1;
        else m_pc = t;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++; if (pc !== 32'h0 || instr !== 32'h0 || opcode !== 7'h0) begin
            miscompares++; $display("FAIL reset_regs pc=%h instr=%h opcode=%h required 0", pc, instr, opcode); end
        vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || retired !== 32'h0 || fault !== 1'b0) begin
            miscompares++; $display("FAIL reset_ctrl req=%b valid=%b retired=%h fault=%b required 0", imem_req, instr_valid, retired, fault); end
        reset = 1'b0;
        tick();
        m_pc = 32'h0; m_ret = 32'h0; m_fault = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_exit req=%b addr=%h valid=%b required 1/0/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
                miscompares++; $display("FAIL seq_addr req=%b addr=%h required 1/%h", imem_req, imem_addr, m_pc); end
            imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
            tick();
            imem_ready = 1'b0;
            vectors++; if (instr_valid !== 1'b1 || opcode !== 7'b0010011 || imem_req !== 1'b0) begin
                miscompares++; $display("FAIL seq_hold valid=%b opcode=%b req=%b required 1/0010011/0", instr_valid, opcode, imem_req); end
            instr_ack = 1'b1; branch = 1'b0;
            tick();
            instr_ack = 1'b0;
            m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1;
        end
        vectors++; if (imem_addr !== 32'd12 || retired !== 32'd3) begin
            miscompares++; $display("FAIL seq_end addr=%h retired=%0d required 0000000c/3", imem_addr, retired); end
    endtask

    task automatic test_branch();
        for (int zv = 1; zv >= 0; zv--) begin
            apply_reset();
            fetch_ack(0, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
            fetch_ack(1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
            vectors++; if (imem_addr !== 32'd8) begin
                miscompares++; $display("FAIL branch_pre addr=%h required 00000008", imem_addr); end
            fetch_ack(0, 32'hFE00_0CE3, 1'b1, 1'(zv), 32'hFFFF_FFF8);
            vectors++; if (imem_addr !== m_pc || imem_req !== 1'b1 || fault !== 1'b0) begin
                miscompares++; $display("FAIL branch_zero%0d addr=%h req=%b fault=%b required %h/1/0", zv, imem_addr, imem_req, fault, m_pc); end
        end
    endtask

    task automatic test_delayed();
        logic [31:0] d;
        d = $urandom;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
                miscompares++; $display("FAIL delay_wait%0d req=%b addr=%h valid=%b required 1/%h/0", i, imem_req, imem_addr, instr_valid, m_pc); end
            instr_ack = 1'($urandom);
            tick();
        end
        instr_ack = 1'b0; imem_ready = 1'b1; imem_rdata = d;
        #1;
        vectors++; if (instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL delay_early valid=%b required 0", instr_valid); end
        tick();
        imem_ready = 1'b0;
        vectors++; if (instr_valid !== 1'b1 || instr !== d) begin
            miscompares++; $display("FAIL delay_capture valid=%b instr=%h required 1/%h", instr_valid, instr, d); end
        branch = 1'b0; instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1;
    endtask

    task automatic test_random();
        logic [31:0] d, imm, t;
        logic        br, z;
        int          w, h;
        for (int n = 0; n < 40; n++) begin
            d = $urandom; w = $urandom_range(0, 3); h = $urandom_range(0, 2);
            br = 1'($urandom); z = 1'($urandom);
            imm = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : (32'($urandom_range(0, 16)) << 2);
            for (int i = 0; i < w; i++) begin
                vectors++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
                    miscompares++; $display("FAIL rnd_wait req=%b addr=%h required 1/%h", imem_req, imem_addr, m_pc); end
                instr_ack = 1'($urandom);
                tick();
            end
            instr_ack = 1'b0; imem_ready = 1'b1; imem_rdata = d;
            tick();
            for (int i = 0; i < h; i++) begin
                imem_ready = 1'b1; imem_rdata = ~d;
                vectors++; if (instr_valid !== 1'b1 || instr !== d || opcode !== d[6:0] || imem_req !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_hold valid=%b instr=%h req=%b required 1/%h/0", instr_valid, instr, imem_req, d); end
                tick();
            end
            imem_ready = 1'b0;
            vectors++; if (instr_valid !== 1'b1 || instr !== d || opcode !== d[6:0]) begin
                miscompares++; $display("FAIL rnd_capture valid=%b instr=%h opcode=%h required 1/%h/%h", instr_valid, instr, opcode, d, d[6:0]); end
            branch = br; zero = z; imm_ext = imm; instr_ack = 1'b1;
            tick();
            instr_ack = 1'b0; branch = 1'($urandom); zero = 1'($urandom); imm_ext = $urandom;
            t = model_target(m_pc, br, z, imm);
            m_pc = t; m_ret = m_ret + 32'd1;
            vectors++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || retired !== m_ret) begin
                miscompares++; $display("FAIL rnd_next pc=%h pc4=%h retired=%0d required %h/%h/%0d", pc, pc_plus4, retired, m_pc, m_pc + 32'd4, m_ret); end
            vectors++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || fault !== 1'b0) begin
                miscompares++; $display("FAIL rnd_ctrl req=%b valid=%b fault=%b required 1/0/0", imem_req, instr_valid, fault); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        fetch_ack(0, 32'h0000_0063, 1'b1, 1'b1, 32'hFFFF_FFFC);
        vectors++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || fault !== 1'b0) begin
            miscompares++; $display("FAIL wrap_top pc=%h pc4=%h fault=%b required fffffffc/0/0", pc, pc_plus4, fault); end
        fetch_ack(2, 32'h0000_0013, 1'b0, 1'b1, 32'h0000_0100);
        vectors++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || retired !== 32'd2) begin
            miscompares++; $display("FAIL wrap_zero addr=%h req=%b retired=%0d required 0/1/2", imem_addr, imem_req, retired); end
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        d = 32'h0060_0063;
        apply_reset();
        fetch_ack(0, d, 1'b1, 1'b1, 32'h0000_0006);
        vectors++; if (fault !== m_fault || pc !== m_pc || retired !== m_ret) begin
            miscompares++; $display("FAIL misalign_state fault=%b pc=%h retired=%0d required %b/%h/%0d", fault, pc, retired, m_fault, m_pc, m_ret); end
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'b1; imem_rdata = $urandom; instr_ack = 1'b1;
            vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b1 || instr !== d || pc !== 32'h0) begin
                miscompares++; $display("FAIL misalign_stuck req=%b valid=%b fault=%b instr=%h pc=%h required 0/0/1/%h/0", imem_req, instr_valid, fault, instr, pc, d); end
            tick();
        end
        imem_ready = 1'b0; instr_ack = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        apply_reset();
        fetch_ack(0, 32'h1234_5677, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        vectors++; if (pc !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b0 || retired !== 32'h0 || instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL midreset_async pc=%h instr=%h req=%b retired=%0d valid=%b required all 0", pc, instr, imem_req, retired, instr_valid); end
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0;
        tick();
        vectors++; if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            miscompares++; $display("FAIL midreset_stale instr=%h valid=%b req=%b required 0/0/1", instr, instr_valid, imem_req); end
        imem_ready = 1'b0;
        tick();
        vectors++; if (instr_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0) begin
            miscompares++; $display("FAIL midreset_after valid=%b fault=%b addr=%h required 0/0/0", instr_valid, fault, imem_addr); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        repeat (15) tick();
        vectors++; if (fault !== 1'b0 || imem_req !== 1'b1) begin
            miscompares++; $display("FAIL timeout_early fault=%b req=%b required 0/1", fault, imem_req); end
        tick();
        vectors++; if (fault !== 1'b1 || imem_req !== 1'b0) begin
            miscompares++; $display("FAIL timeout_fire fault=%b req=%b required 1/0", fault, imem_req); end
        apply_reset();
        repeat (15) tick();
        imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ready = 1'b0;
        vectors++; if (fault !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL timeout_readywins fault=%b valid=%b instr=%h required 0/1/cafef00d", fault, instr_valid, instr); end
    endtask
`else
    task automatic test_timeout();
        apply_reset();
        repeat (40) tick();
        vectors++; if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++; $display("FAIL nowait_limit fault=%b req=%b addr=%h required 0/1/0", fault, imem_req, imem_addr); end
        imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ready = 1'b0;
        vectors++; if (fault !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL nowait_capture fault=%b valid=%b instr=%h required 0/1/cafef00d", fault, instr_valid, instr); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_delayed();
        test_random();
        test_wrap();
        test_misaligned();
        test_reset_midfetch();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
